memory_be: RTL

MEMORY_BE -- requirements
Module: memory_be

---
 rtl/memory_be.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/memory_be.sv
// Dual-port (fetch + data) word memory with byte/half/word data accesses,
// sign/zero-extended loads, misalignment errors and 1- or 2-cycle read latency.
module memory_be #(
    parameter int    AWIDTH     = 16,
    parameter int    RD_LATENCY = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_inst,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err
);
    localparam int WORD_LEN = 32;
    localparam int DEPTH    = 1 << (AWIDTH - 2);

    logic [WORD_LEN-1:0] mem [0:DEPTH-1];

    logic [AWIDTH-3:0] i_idx, d_idx;
    logic              unused_addr;
    assign i_idx       = i_addr[AWIDTH-1:2];
    assign d_idx       = d_addr[AWIDTH-1:2];
    assign unused_addr = ^{i_addr[31:AWIDTH], i_addr[1:0], d_addr[31:AWIDTH]};

    // Request decode: lane enables, lane-replicated store data, alignment error
    logic [3:0]  be;
    logic [31:0] wlane;
    logic        err_c, we;
    always_comb begin
        be    = 4'b0000;
        wlane = d_wdata;
        err_c = 1'b0;
        case (d_size)
            2'd0: begin
                be    = 4'b0001 << d_addr[1:0];
                wlane = {4{d_wdata[7:0]}};
            end
            2'd1: begin
                be    = d_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{d_wdata[15:0]}};
                err_c = d_addr[0];
            end
            2'd2: begin
                be    = 4'b1111;
                err_c = |d_addr[1:0];
            end
            default: err_c = 1'b1;
        endcase
    end
    assign we = rst_n && d_req && d_wen && !err_c;

    // Storage: no reset so it maps onto block RAM with byte write enables
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && be[b]) mem[d_idx][8*b +: 8] <= wlane[8*b +: 8];
    end

    // Stage 1: synchronous read (read-first) plus request attributes
    logic [31:0] i_word, d_word;
    logic        i_vld1, d_vld1, d_err1, d_ld1, d_uns1;
    logic [1:0]  d_size1, d_off1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_word  <= '0;
            d_word  <= '0;
            i_vld1  <= 1'b0;
            d_vld1  <= 1'b0;
            d_err1  <= 1'b0;
            d_ld1   <= 1'b0;
            d_uns1  <= 1'b0;
            d_size1 <= '0;
            d_off1  <= '0;
        end else begin
            if (i_req) i_word <= mem[i_idx];
            if (d_req) d_word <= mem[d_idx];
            i_vld1  <= i_req;
            d_vld1  <= d_req;
            d_err1  <= d_req && err_c;
            d_ld1   <= d_req && !d_wen && !err_c;
            d_uns1  <= d_unsigned;
            d_size1 <= d_size;
            d_off1  <= d_addr[1:0];
        end
    end

    // Load alignment and extension
    logic [15:0] sh;
    logic [31:0] ext, ld_res;
    assign sh = 16'(d_word >> {d_off1, 3'b000});
    always_comb begin
        case (d_size1)
            2'd0:    ext = d_uns1 ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    ext = d_uns1 ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ext = d_word;
        endcase
    end
    assign ld_res = d_ld1 ? ext : 32'b0;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic        i_valid_q, d_valid_q, d_err_q;
            logic [31:0] i_inst_q, d_rdata_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    i_valid_q <= 1'b0;
                    i_inst_q  <= '0;
                    d_valid_q <= 1'b0;
                    d_err_q   <= 1'b0;
                    d_rdata_q <= '0;
                end else begin
                    i_valid_q <= i_vld1;
                    if (i_vld1) i_inst_q <= i_word;
                    d_valid_q <= d_vld1;
                    d_err_q   <= d_err1;
                    d_rdata_q <= ld_res;
                end
            end
            assign i_valid = i_valid_q;
            assign i_inst  = i_inst_q;
            assign d_valid = d_valid_q;
            assign d_err   = d_err_q;
            assign d_rdata = d_rdata_q;
        end else begin : g_lat1
            assign i_valid = i_vld1;
            assign i_inst  = i_word;
            assign d_valid = d_vld1;
            assign d_err   = d_err1;
            assign d_rdata = ld_res;
        end
    endgenerate
endmodule
